nmr_echo_capture: RTL

Acquisition gate that sits directly downstream of the NMR pulse sequencer. It watches the sequencer's `sync_out` and `blank_out`, and opens one capture window every time blanking ends. The first window is the FID after the A-pulse; each following window is an echo after a B-pulse. In each window it decimates ADC samples by boxcar summation and pushes the tagged sums through a small FIFO onto an AXI-Stream master for the DMA.

---
 rtl/nmr_echo_capture.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/nmr_echo_capture.sv
// Acquisition gate behind the NMR pulse sequencer: opens a capture window at every blanking
// release, boxcar-decimates ADC samples and streams tagged sums through a FIFO to AXI-Stream.
module nmr_echo_capture #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        disarm,
   input  logic        sync_in,
   input  logic        blank_in,
   input  logic [15:0] adc_data,
   input  logic        adc_valid,
   input  logic [15:0] win_len_in,
   input  logic [7:0]  decim_in,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        busy,
   output logic        overflow,
   output logic [15:0] win_count,
   output logic [1:0]  dbg_state
);

   localparam int          AW     = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_ARMED      = 2'd1,
      S_WAIT_BLANK = 2'd2,
      S_CAPTURE    = 2'd3
   } state_t;

   state_t      r_state, w_state_next;
   logic        r_sync_q, r_blank_q;
   logic        w_sync_rise, w_blank_fall;
   logic [7:0]  r_decim;
   logic [15:0] r_win_last;
   logic [6:0]  r_echo;
   logic [23:0] r_acc;
   logic [7:0]  r_samp_cnt;
   logic [15:0] r_beat_cnt;
   logic [15:0] r_win_count;
   logic        r_overflow;
   logic [23:0] w_acc_sum;
   logic        w_group_done, w_last_beat, w_has_data;
   logic        w_do_arm, w_shot_start, w_win_open, w_trunc, w_sample;
   logic        w_beat, w_emit_trunc, w_win_end;
   logic        r_bp_valid;
   logic [32:0] r_bp_data;
   logic [32:0] r_mem [0:FIFO_DEPTH-1];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0] r_count;
   logic        r_valid;
   logic        w_pop, w_full, w_push, w_drop;

   assign w_sync_rise  = sync_in & ~r_sync_q;
   assign w_blank_fall = r_blank_q & ~blank_in;
   assign w_acc_sum    = r_acc + {{8{adc_data[15]}}, adc_data};
   assign w_group_done = (r_samp_cnt == r_decim);
   assign w_last_beat  = (r_beat_cnt == r_win_last);
   assign w_has_data   = (r_beat_cnt != 16'd0) || (r_samp_cnt != 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sync_q  <= 1'b0;
         r_blank_q <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_sync_q  <= sync_in;
         r_blank_q <= blank_in;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (disarm) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:       if (arm) w_state_next = S_ARMED;
            S_ARMED:      if (w_sync_rise) w_state_next = S_WAIT_BLANK;
            S_WAIT_BLANK: if (w_blank_fall) w_state_next = S_CAPTURE;
            S_CAPTURE: begin
               // An early blank means the next pulse arrived: the window closes at once.
               if (blank_in)
                  w_state_next = S_WAIT_BLANK;
               else if (adc_valid && w_group_done && w_last_beat)
                  w_state_next = S_WAIT_BLANK;
            end
            default:      w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = (r_state != S_IDLE);
      dbg_state    = r_state;
      w_do_arm     = 1'b0;
      w_shot_start = 1'b0;
      w_win_open   = 1'b0;
      w_trunc      = 1'b0;
      w_sample     = 1'b0;
      if (!disarm) begin
         case (r_state)
            S_IDLE:       w_do_arm = arm;
            S_ARMED:      w_shot_start = w_sync_rise;
            S_WAIT_BLANK: begin
               w_shot_start = w_sync_rise;
               w_win_open   = w_blank_fall;
            end
            S_CAPTURE: begin
               w_trunc  = blank_in;
               w_sample = ~blank_in & adc_valid;
            end
            default: ;
         endcase
      end
      w_beat       = w_sample & w_group_done;
      w_emit_trunc = w_trunc & w_has_data;
      w_win_end    = (w_beat & w_last_beat) | w_trunc;
   end

   // Completed beats sit in r_bp_* for one cycle before the FIFO write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_decim     <= 8'd0;
         r_win_last  <= 16'd0;
         r_echo      <= 7'd0;
         r_acc       <= 24'd0;
         r_samp_cnt  <= 8'd0;
         r_beat_cnt  <= 16'd0;
         r_win_count <= 16'd0;
         r_bp_valid  <= 1'b0;
         r_bp_data   <= 33'd0;
      end else begin
         if (w_do_arm) begin
            r_decim     <= decim_in;
            r_win_last  <= (win_len_in == 16'd0) ? 16'd0 : win_len_in - 16'd1;
            r_win_count <= 16'd0;
         end
         if (w_shot_start)
            r_echo <= 7'd0;
         if (w_win_open) begin
            r_acc      <= 24'd0;
            r_samp_cnt <= 8'd0;
            r_beat_cnt <= 16'd0;
         end
         if (w_sample) begin
            if (w_group_done) begin
               r_acc      <= 24'd0;
               r_samp_cnt <= 8'd0;
               r_beat_cnt <= r_beat_cnt + 16'd1;
            end else begin
               r_acc      <= w_acc_sum;
               r_samp_cnt <= r_samp_cnt + 8'd1;
            end
         end
         if (w_win_end) begin
            r_echo <= r_echo + 7'd1;
            if (r_win_count != 16'hFFFF)
               r_win_count <= r_win_count + 16'd1;
         end
         r_bp_valid <= w_beat | w_emit_trunc;
         if (w_emit_trunc)
            r_bp_data <= {1'b1, 1'b1, r_echo, r_acc};
         else
            r_bp_data <= {w_last_beat, 1'b0, r_echo, w_acc_sum};
      end
   end

   // m_tvalid/m_tready: a beat transfers on a clk edge where both are high; once m_tvalid is
   // high it stays high with m_tdata/m_tlast unchanged until that transfer happens.
   assign w_pop  = r_valid & m_tready;
   assign w_full = (r_count == C_FULL);
   assign w_push = r_bp_valid & (~w_full | w_pop);
   assign w_drop = r_bp_valid & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (!rst && w_push)
         r_mem[r_wr_ptr] <= r_bp_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: ;
         endcase
         // Entries written this cycle become visible one cycle later.
         r_valid <= ((r_count - (AW+1)'(w_pop)) != '0);
         if (w_drop)
            r_overflow <= 1'b1;
         else if (w_do_arm)
            r_overflow <= 1'b0;
      end
   end

   assign m_tvalid  = r_valid;
   assign m_tdata   = r_valid ? r_mem[r_rd_ptr][31:0] : 32'd0;
   assign m_tlast   = r_valid ? r_mem[r_rd_ptr][32] : 1'b0;
   assign overflow  = r_overflow;
   assign win_count = r_win_count;

endmodule
